sccb_write_master: RTL and testbench
====================================

// Module: sccb_write_master
// PURPOSE
//  SCCB (I2C-like) 3-phase write transmitter that programs camera registers over SIOC/SIOD.
//  It is the consumer end of the 100 kHz SCCB clock: the divider is internal and derived from parameters.
//  Sits between the register-init sequencer (valid/ready command stream) and the camera pads.
//  Tri-state buffering lives in the top level, driven by siod_o and siod_oe_o.
// PARAMETERS
//  CLK_FREQ_HZ   100_000_000  system clock frequency
//  SCCB_FREQ_HZ  100_000      SIOC frequency
//  QUARTER = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) is a localparam (default 250). Must be >=1; elaboration error if 0.
// PORTS
//  clk_i        in   1  system clock
//  reset_i      in   1  synchronous, active-high reset
//  cmd_valid_i  in   1  command present
//  cmd_ready_o  out  1  block idle and able to accept a command
//  dev_id_i     in   8  phase-1 byte (ID | write bit, e.g. 0x42)
//  reg_addr_i   in   8  phase-2 sub-address
//  reg_data_i   in   8  phase-3 write data
//  sioc_o       out  1  SCCB clock
//  siod_o       out  1  SCCB data value
//  siod_oe_o    out  1  1 = drive siod_o onto the pad, 0 = release (pull-up)
//  done_o       out  1  one-cycle pulse when a transaction completes
// BEHAVIOUR
//  - Clock and reset: one clock (clk_i); reset_i is synchronous and active-high. All outputs are registered.
//  - Reset values: sioc_o=1, siod_o=1, siod_oe_o=1, cmd_ready_o=1, done_o=0, quarter counter=0, state=IDLE.
//  - Timebase: a quarter counter counts 0..QUARTER-1. Each wrap is one "quarter". The counter runs only outside IDLE.
//  - Handshake: a command is accepted on a cycle with cmd_valid_i && cmd_ready_o.
//      - The three bytes are latched in that cycle.
//      - cmd_ready_o drops the next cycle.
//      - cmd_valid_i while busy is ignored.
//  - FSM IDLE -> START -> BITS -> STOP -> GAP -> IDLE:
//    - START, 2 quarters: Q0 sioc=1, siod=1; Q1 sioc=1, siod=0.
//    - BITS, 27 slots (3 phases x 9 bits), 4 quarters per slot:
//        - Q0 and Q1: sioc=0. siod is updated at the start of Q0.
//        - Q2 and Q3: sioc=1.
//        - Bits 0-7 of each phase are sent MSB first with siod_oe_o=1.
//        - Bit 8 is don't-care: siod_oe_o=0 and siod_o=1 for all 4 quarters.
//    - STOP, 4 quarters: Q0 and Q1 sioc=0, siod=0. Q2 sioc=1, siod=0. Q3 sioc=1, siod=1.
//    - GAP, 4 quarters: bus idle (sioc=1, siod=1, oe=1) to guarantee bus-free time.
//  - Completion: done_o=1 and cmd_ready_o=1 in the last cycle of GAP.
//      - Total is 118 quarters, so done_o occurs exactly 118*QUARTER cycles after the accept cycle (29500 at defaults).
//      - A command presented in the done_o cycle is accepted (back-to-back).
//      - The next START begins on the following cycle.
//  - Bit/phase counters: a 5-bit slot index 0..26 and a 2-bit quarter index. The byte shift register reloads at slots 9 and 18.
//  - Reset mid-transaction: the next cycle is in IDLE with the bus released high, and no stop is generated. The camera resynchronises on the next START.
//  - reset_i has priority over cmd_valid_i in the same cycle.
// CONFIGURATION
//  Macro SCCB_NACK_CHECK_EN controls don't-care-bit sampling.
//  Defined:
//   - Adds port siod_i (in, 1) and port nack_o (out, 1, reset 0).
//   - siod_i is sampled in the first cycle of Q2 of each bit-8 slot.
//   - If any of the 3 samples is 1, nack_o=1 in the done_o cycle; otherwise nack_o=0.
//   - nack_o holds its value until the next accept, then clears.
//  Undefined: ports siod_i and nack_o do not exist, and bit 8 is never sampled.
// TESTING (run with CLK_FREQ_HZ=400, SCCB_FREQ_HZ=100 -> QUARTER=1, unless noted)
//  1. Reset 2 cycles -> sioc_o=1, siod_o=1, siod_oe_o=1, cmd_ready_o=1, done_o=0.
//  2. Write 0x42/0x12/0x80 -> siod_o sampled at every sioc_o rising edge reads 0x42, x, 0x12, x, 0x80, x.
//       - oe=0 on the x slots.
//       - START and STOP edges as specified.
//       - done_o exactly 118 cycles after the accept.
//  3. Hold cmd_valid_i high with two commands -> second accepted in the done_o cycle.
//       - cmd_ready_o is low for the whole of each transaction.
//       - The second START begins the cycle after done_o.
//  4. Assert reset_i at slot 10 -> next cycle sioc=1, siod=1, oe=1, ready=1.
//       - No done_o.
//       - A new command then completes normally.
//  5. Default parameters: write 0x42/0x3A/0x04 -> sioc_o period = 1000 cycles (10 us); done_o after 29500 cycles.
//  6. With SCCB_NACK_CHECK_EN: siod_i=0 throughout -> nack_o=0; siod_i=1 on phase-2 bit 8 -> nack_o=1 with done_o.

Source files
------------

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: START, 27 bit slots (3 bytes + don't-care bit), STOP, bus-free gap.
// Optional macro SCCB_NACK_CHECK_EN adds siod_i sampling of the don't-care bits and a nack_o flag.
module sccb_write_master #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] dev_id_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    output logic       sioc_o,
    output logic       siod_o,
    output logic       siod_oe_o,
`ifdef SCCB_NACK_CHECK_EN
    output logic       done_o,
    input  logic       siod_i,
    output logic       nack_o
`else
    output logic       done_o
`endif
);

    localparam int unsigned QUARTER = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int unsigned QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QMAX  = QW'(QUARTER - 1);

    if (QUARTER < 1) begin : gen_quarter_check
        $error("sccb_write_master: CLK_FREQ_HZ must be at least 4*SCCB_FREQ_HZ");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBits,
        StStop,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      qidx_q, qidx_d;
    logic [4:0]      slot_q, slot_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      addr_q, data_q;

    logic            accept;
    logic            quarter_end;
    logic            slot_start;
    logic [7:0]      src_byte;
    logic            sioc_d, siod_d, oe_d, done_d, ready_d;

    assign accept      = cmd_valid_i && cmd_ready_o;
    assign quarter_end = (qcnt_q == QMAX);

    // Position update: quarter counter, quarter index, slot and bit-in-phase.
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        qidx_d     = qidx_q;
        slot_d     = slot_q;
        bit_d      = bit_q;
        slot_start = 1'b0;

        if (state_q != StIdle) begin
            qcnt_d = quarter_end ? '0 : qcnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    qidx_d  = 2'd0;
                    qcnt_d  = '0;
                end
            end
            StStart: begin
                if (quarter_end) begin
                    if (qidx_q == 2'd1) begin
                        state_d    = StBits;
                        qidx_d     = 2'd0;
                        slot_d     = 5'd0;
                        bit_d      = 4'd0;
                        slot_start = 1'b1;
                    end else begin
                        qidx_d = qidx_q + 2'd1;
                    end
                end
            end
            StBits: begin
                if (quarter_end) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        if (slot_q == 5'd26) begin
                            state_d = StStop;
                        end else begin
                            slot_d     = slot_q + 5'd1;
                            bit_d      = (bit_q == 4'd8) ? 4'd0 : bit_q + 4'd1;
                            slot_start = 1'b1;
                        end
                    end
                end
            end
            StStop: begin
                if (quarter_end) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (quarter_end) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        // Back-to-back: a command taken in the done cycle starts immediately.
                        state_d = accept ? StStart : StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are derived from the next position so they can be registered.
    always_comb begin
        sioc_d   = 1'b1;
        siod_d   = 1'b1;
        oe_d     = 1'b1;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        shreg_d  = shreg_q;
        src_byte = shreg_q;

        case (state_d)
            StIdle: begin
                ready_d = 1'b1;
            end
            StStart: begin
                siod_d = (qidx_d == 2'd0);
            end
            StBits: begin
                sioc_d = qidx_d[1];
                if (bit_d == 4'd8) begin
                    oe_d   = 1'b0;
                    siod_d = 1'b1;
                end else if (slot_start) begin
                    if (slot_d == 5'd9) begin
                        src_byte = addr_q;
                    end else if (slot_d == 5'd18) begin
                        src_byte = data_q;
                    end
                    siod_d  = src_byte[7];
                    shreg_d = {src_byte[6:0], 1'b0};
                end else begin
                    siod_d = siod_o;
                end
            end
            StStop: begin
                sioc_d = qidx_d[1];
                siod_d = (qidx_d == 2'd3);
            end
            StGap: begin
                if ((qidx_d == 2'd3) && (qcnt_d == QMAX)) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

`ifdef SCCB_NACK_CHECK_EN
    logic nack_acc_q;
    logic nack_sample;

    // First cycle of Q2 in a don't-care slot: the slave drives its ACK level here.
    assign nack_sample = (state_q == StBits) && (bit_q == 4'd8) && (qidx_q == 2'd2) &&
                         (qcnt_q == '0) && siod_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            qcnt_q      <= '0;
            qidx_q      <= 2'd0;
            slot_q      <= 5'd0;
            bit_q       <= 4'd0;
            shreg_q     <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            sioc_o      <= 1'b1;
            siod_o      <= 1'b1;
            siod_oe_o   <= 1'b1;
            cmd_ready_o <= 1'b1;
            done_o      <= 1'b0;
`ifdef SCCB_NACK_CHECK_EN
            nack_acc_q  <= 1'b0;
            nack_o      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            qidx_q      <= qidx_d;
            slot_q      <= slot_d;
            bit_q       <= bit_d;
            sioc_o      <= sioc_d;
            siod_o      <= siod_d;
            siod_oe_o   <= oe_d;
            cmd_ready_o <= ready_d;
            done_o      <= done_d;
            if (accept) begin
                shreg_q <= dev_id_i;
                addr_q  <= reg_addr_i;
                data_q  <= reg_data_i;
            end else begin
                shreg_q <= shreg_d;
            end
`ifdef SCCB_NACK_CHECK_EN
            if (accept) begin
                nack_acc_q <= 1'b0;
                nack_o     <= 1'b0;
            end else begin
                if (nack_sample) begin
                    nack_acc_q <= 1'b1;
                end
                if (done_d) begin
                    nack_o <= nack_acc_q | nack_sample;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: a QUARTER=1 instance for protocol detail and a
// default-parameter instance for real-time timing. Honours SCCB_NACK_CHECK_EN.
module tb_sccb_write_master;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cmd_valid;
    logic [7:0] dev_id, reg_addr, reg_data;
    logic       cmd_ready, sioc, siod, siod_oe, done;

    logic       cmd_valid_d;
    logic [7:0] dev_id_d, reg_addr_d, reg_data_d;
    logic       cmd_ready_d, sioc_d, siod_d, siod_oe_d, done_d;

`ifdef SCCB_NACK_CHECK_EN
    logic siod_in;
    logic siod_in_d;
    logic nack;
    logic nack_d;
`endif

    sccb_write_master #(
        .CLK_FREQ_HZ (400),
        .SCCB_FREQ_HZ(100)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .dev_id_i   (dev_id),
        .reg_addr_i (reg_addr),
        .reg_data_i (reg_data),
        .sioc_o     (sioc),
        .siod_o     (siod),
        .siod_oe_o  (siod_oe),
`ifdef SCCB_NACK_CHECK_EN
        .done_o     (done),
        .siod_i     (siod_in),
        .nack_o     (nack)
`else
        .done_o     (done)
`endif
    );

    sccb_write_master dut_def (
        .clk_i      (clk),
        .reset_i    (reset),
        .cmd_valid_i(cmd_valid_d),
        .cmd_ready_o(cmd_ready_d),
        .dev_id_i   (dev_id_d),
        .reg_addr_i (reg_addr_d),
        .reg_data_i (reg_data_d),
        .sioc_o     (sioc_d),
        .siod_o     (siod_d),
        .siod_oe_o  (siod_oe_d),
`ifdef SCCB_NACK_CHECK_EN
        .done_o     (done_d),
        .siod_i     (siod_in_d),
        .nack_o     (nack_d)
`else
        .done_o     (done_d)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Per-cycle record of the fast instance; index k = cycles after the accept cycle.
    logic [2:0] rec_bus   [0:399];  // {sioc, siod, oe}
    logic       rec_done  [0:399];
    logic       rec_ready [0:399];
    logic       rec_nack  [0:399];
    logic       edge_siod [$];
    logic       edge_oe   [$];

    task automatic record(input int n, input int k_drop, input int k_swap,
                          input logic [23:0] swap_cmd, input int k_rst,
                          input int k_hi_on, input int k_hi_off);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            rec_bus[k]   = {sioc, siod, siod_oe};
            rec_done[k]  = done;
            rec_ready[k] = cmd_ready;
`ifdef SCCB_NACK_CHECK_EN
            rec_nack[k]  = nack;
            if (k == k_hi_on)  siod_in = 1'b1;
            if (k == k_hi_off) siod_in = 1'b0;
`else
            rec_nack[k]  = 1'b0;
            if (k == k_hi_on || k == k_hi_off) rec_nack[k] = 1'b0;
`endif
            if (k == k_drop) cmd_valid = 1'b0;
            if (k == k_swap) {dev_id, reg_addr, reg_data} = swap_cmd;
            reset = (k == k_rst);
        end
    endtask

    task automatic collect_edges(input int from, input int to);
        edge_siod.delete();
        edge_oe.delete();
        for (int k = from; k <= to; k++) begin
            if (rec_bus[k][2] === 1'b1 && rec_bus[k-1][2] === 1'b0) begin
                edge_siod.push_back(rec_bus[k][1]);
                edge_oe.push_back(rec_bus[k][0]);
            end
        end
    endtask

    function automatic logic [7:0] edge_byte(input int p);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], edge_siod[p*9+i]};
        return b;
    endfunction

    // 1 when the byte slots were driven and the ninth slot was released high.
    function automatic logic edge_oe_ok(input int p);
        logic ok = (edge_oe[p*9+8] === 1'b0) && (edge_siod[p*9+8] === 1'b1);
        for (int i = 0; i < 8; i++) ok = ok && (edge_oe[p*9+i] === 1'b1);
        return ok;
    endfunction

    function automatic int first_done(input int from, input int to);
        for (int k = from; k <= to; k++) if (rec_done[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic start_cmd(input logic [23:0] cmd);
        @(negedge clk);
        {dev_id, reg_addr, reg_data} = cmd;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 1'b1;  // reset must win over a pending command
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({sioc, siod, siod_oe, cmd_ready, done} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=11110", {sioc, siod, siod_oe, cmd_ready, done});
        end
        total++;
        if ({sioc_d, siod_d, siod_oe_d, cmd_ready_d, done_d} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_outputs_default got=%b want=11110",
                     {sioc_d, siod_d, siod_oe_d, cmd_ready_d, done_d});
        end
`ifdef SCCB_NACK_CHECK_EN
        total++;
        if (nack !== 1'b0) begin
            bad++;
            $display("FAIL reset_nack got=%b want=0", nack);
        end
`endif
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({cmd_ready, sioc} !== 2'b11) begin
            bad++;
            $display("FAIL reset_no_accept got=%b want=11", {cmd_ready, sioc});
        end
    endtask

    task automatic test_write;
        int cnt;
        start_cmd({8'h42, 8'h12, 8'h80});
        record(125, 1, -1, 24'h0, -1, -1, -1);
        total++;
        if (rec_bus[1] !== 3'b111 || rec_bus[2] !== 3'b101) begin
            bad++;
            $display("FAIL write_start got=%b,%b want=111,101", rec_bus[1], rec_bus[2]);
        end
        collect_edges(3, 114);
        total++;
        if (edge_siod.size() != 28) begin
            bad++;
            $display("FAIL write_edge_count got=%0d want=28", edge_siod.size());
        end else begin
            total++;
            if ({edge_byte(0), edge_byte(1), edge_byte(2)} !== 24'h421280) begin
                bad++;
                $display("FAIL write_bytes got=%h want=421280",
                         {edge_byte(0), edge_byte(1), edge_byte(2)});
            end
            total++;
            if ({edge_oe_ok(0), edge_oe_ok(1), edge_oe_ok(2)} !== 3'b111) begin
                bad++;
                $display("FAIL write_oe_slots got=%b want=111",
                         {edge_oe_ok(0), edge_oe_ok(1), edge_oe_ok(2)});
            end
        end
        total++;
        if ({rec_bus[111], rec_bus[112], rec_bus[113], rec_bus[114]} !== 12'b001_001_101_111) begin
            bad++;
            $display("FAIL write_stop got=%b want=001001101111",
                     {rec_bus[111], rec_bus[112], rec_bus[113], rec_bus[114]});
        end
        total++;
        if ({rec_bus[115], rec_bus[118], rec_bus[120]} !== 9'b111_111_111) begin
            bad++;
            $display("FAIL write_gap_idle got=%b want=111111111",
                     {rec_bus[115], rec_bus[118], rec_bus[120]});
        end
        total++;
        if (first_done(1, 125) != 118 || rec_done[119] !== 1'b0) begin
            bad++;
            $display("FAIL write_done_cycle got=%0d want=118", first_done(1, 125));
        end
        cnt = 0;
        for (int k = 1; k <= 117; k++) if (rec_ready[k] !== 1'b0) cnt++;
        total++;
        if (cnt != 0 || rec_ready[118] !== 1'b1 || rec_ready[119] !== 1'b1) begin
            bad++;
            $display("FAIL write_ready got=%0d early-highs,last=%b want=0,1", cnt, rec_ready[118]);
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        start_cmd({8'h60, 8'hA5, 8'h3C});
        record(240, 236, 118, {8'h21, 8'h43, 8'h65}, -1, -1, -1);
        total++;
        if (first_done(1, 240) != 118 || first_done(119, 240) != 236) begin
            bad++;
            $display("FAIL b2b_done got=%0d,%0d want=118,236", first_done(1, 240),
                     first_done(119, 240));
        end
        cnt = 0;
        for (int k = 1; k <= 235; k++) if (k != 118 && rec_ready[k] !== 1'b0) cnt++;
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL b2b_ready_busy got=%0d want=0", cnt);
        end
        total++;
        if (rec_bus[119] !== 3'b111 || rec_bus[120] !== 3'b101) begin
            bad++;
            $display("FAIL b2b_second_start got=%b,%b want=111,101", rec_bus[119], rec_bus[120]);
        end
        collect_edges(3, 114);
        total++;
        if (edge_siod.size() != 28 || {edge_byte(0), edge_byte(1), edge_byte(2)} !== 24'h60A53C) begin
            bad++;
            $display("FAIL b2b_first_bytes got=%h want=60a53c",
                     {edge_byte(0), edge_byte(1), edge_byte(2)});
        end
        collect_edges(121, 232);
        total++;
        if (edge_siod.size() != 28 || {edge_byte(0), edge_byte(1), edge_byte(2)} !== 24'h214365) begin
            bad++;
            $display("FAIL b2b_second_bytes got=%h want=214365",
                     {edge_byte(0), edge_byte(1), edge_byte(2)});
        end
        total++;
        if (rec_ready[237] !== 1'b1 || rec_bus[238] !== 3'b111) begin
            bad++;
            $display("FAIL b2b_idle_after got=%b,%b want=1,111", rec_ready[237], rec_bus[238]);
        end
    endtask

    task automatic test_reset_mid;
        int cnt;
        start_cmd({8'h42, 8'h12, 8'h80});
        record(130, 1, -1, 24'h0, 43, -1, -1);  // k=43 is slot 10, Q0
        total++;
        if (rec_bus[43][2] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_in_slot got=%b want=0", rec_bus[43][2]);
        end
        total++;
        if ({rec_bus[44], rec_ready[44]} !== 4'b1111) begin
            bad++;
            $display("FAIL rstmid_released got=%b want=1111", {rec_bus[44], rec_ready[44]});
        end
        cnt = 0;
        for (int k = 44; k <= 130; k++) if (rec_bus[k] !== 3'b111 || rec_done[k] !== 1'b0) cnt++;
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL rstmid_quiet got=%0d want=0", cnt);
        end
        start_cmd({8'h55, 8'hAA, 8'h0F});
        record(120, 1, -1, 24'h0, -1, -1, -1);
        collect_edges(3, 114);
        total++;
        if (first_done(1, 120) != 118 || edge_siod.size() != 28 ||
            {edge_byte(0), edge_byte(1), edge_byte(2)} !== 24'h55AA0F) begin
            bad++;
            $display("FAIL rstmid_recover got=%0d,%h want=118,55aa0f", first_done(1, 120),
                     {edge_byte(0), edge_byte(1), edge_byte(2)});
        end
    endtask

    task automatic test_default_params;
        int   edges [$];
        logic bits  [$];
        logic prev;
        int   done_k = -1;
        logic [23:0] got = 24'h0;
        @(negedge clk);
        {dev_id_d, reg_addr_d, reg_data_d} = {8'h42, 8'h3A, 8'h04};
        cmd_valid_d = 1'b1;
        prev = sioc_d;
        for (int k = 1; k <= 30000; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid_d = 1'b0;
            if (sioc_d === 1'b1 && prev === 1'b0) begin
                edges.push_back(k);
                bits.push_back(siod_d);
            end
            prev = sioc_d;
            if (done_d === 1'b1) begin
                done_k = k;
                break;
            end
        end
        total++;
        if (done_k != 29500) begin
            bad++;
            $display("FAIL default_done got=%0d want=29500", done_k);
        end
        total++;
        if (edges.size() != 28) begin
            bad++;
            $display("FAIL default_edge_count got=%0d want=28", edges.size());
        end else begin
            total++;
            if (edges[0] != 1001 || edges[1] - edges[0] != 1000) begin
                bad++;
                $display("FAIL default_sioc_period got=%0d,%0d want=1001,1000", edges[0],
                         edges[1] - edges[0]);
            end
            for (int p = 0; p < 3; p++)
                for (int i = 0; i < 8; i++) got = {got[22:0], bits[p*9+i]};
            total++;
            if (got !== 24'h423A04) begin
                bad++;
                $display("FAIL default_bytes got=%h want=423a04", got);
            end
        end
    endtask

`ifdef SCCB_NACK_CHECK_EN
    task automatic test_nack;
        siod_in = 1'b0;
        start_cmd({8'h42, 8'h12, 8'h80});
        record(120, 1, -1, 24'h0, -1, -1, -1);
        total++;
        if (rec_nack[118] !== 1'b0 || rec_done[118] !== 1'b1) begin
            bad++;
            $display("FAIL nack_clean got=%b,%b want=0,1", rec_nack[118], rec_done[118]);
        end
        start_cmd({8'h42, 8'h12, 8'h80});
        record(122, 1, -1, 24'h0, -1, 70, 74);  // high across slot 17 (phase-2 bit 8)
        total++;
        if ({rec_nack[117], rec_nack[118], rec_nack[122]} !== 3'b011) begin
            bad++;
            $display("FAIL nack_set got=%b want=011", {rec_nack[117], rec_nack[118], rec_nack[122]});
        end
        start_cmd({8'h42, 8'h12, 8'h80});
        record(120, 1, -1, 24'h0, -1, -1, -1);
        total++;
        if (rec_nack[0] !== 1'b1 || rec_nack[1] !== 1'b0) begin
            bad++;
            $display("FAIL nack_clear got=%b,%b want=1,0", rec_nack[0], rec_nack[1]);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        {dev_id, reg_addr, reg_data} = 24'h0;
        cmd_valid_d = 1'b0;
        {dev_id_d, reg_addr_d, reg_data_d} = 24'h0;
`ifdef SCCB_NACK_CHECK_EN
        siod_in = 1'b0;
        siod_in_d = 1'b0;
`endif
        test_reset();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_default_params();
`ifdef SCCB_NACK_CHECK_EN
        test_nack();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
